// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   IFU_ADDR_W    : default PC / ROM address width
//   IFU_DATA_W    : default instruction word width
//   IFU_DEPTH     : default fetch buffer depth
//   fetch_entry_t : one buffered fetch, instruction word plus the PC it came from
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 6;
  localparam int IFU_DATA_W = 32;
  localparam int IFU_DEPTH  = 2;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] word;
    logic [IFU_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO holding fetched words for decode.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears storage too)
//   flush      : discard every entry; overrides push and pop
//   push       : write push_entry (ignored when full without a pop)
//   push_entry : entry to write
//   pop        : consume the head (ignored when empty)
//   head       : entry at the head; holds the last popped entry when empty
//   count      : number of valid entries
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = IFU_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   head_idx;
  logic               do_pop;
  logic               do_push;

  assign do_pop  = pop && (count != '0);
  // Full with a simultaneous pop still accepts the push: the slot being
  // written is the one being read out this same cycle.
  assign do_push = push && ((count < CNT_W'(DEPTH)) || do_pop);

  // When empty, point one slot behind rd_ptr so the head keeps showing the
  // most recently consumed entry instead of whatever stale slot is next.
  assign head_idx = (count == '0) ? rd_ptr - PTR_W'(1) : rd_ptr;
  assign head     = mem[head_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      count <= '0;
      // Step past the current head so the empty-FIFO head view stays on it.
      if (count != '0) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        wr_ptr <= rd_ptr + PTR_W'(1);
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: drives the instruction ROM address, buffers fetched words
// with their PC and presents them to decode over valid/ready.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   pc_addr        : ROM address (current fetch PC)
//   rom_data       : ROM word, combinational from pc_addr
//   instr_out      : instruction at the buffer head
//   instr_pc       : PC of instr_out
//   instr_valid    : buffer head valid
//   instr_ready    : decode accepts the head this cycle
//   redirect_valid : branch/jump redirect, flushes the buffer
//   redirect_pc    : redirect target
//   fetch_done     : fetch halted on a zero word and buffer drained
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W       = IFU_ADDR_W,
  parameter int DATA_W       = IFU_DATA_W,
  parameter int DEPTH        = IFU_DEPTH,
  parameter bit STOP_ON_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } ifu_entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic              stopped;
  logic [CNT_W-1:0]  count;
  ifu_entry_t        head;
  ifu_entry_t        push_entry;
  logic              pop;
  logic              push_ok;
  logic              zero_word;
  logic              push;

  assign pc_addr     = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_out   = head.word;
  assign instr_pc    = head.pc;
  assign fetch_done  = stopped && (count == '0);

  assign pop        = instr_valid && instr_ready;
  assign push_ok    = !stopped && ((count < CNT_W'(DEPTH)) || pop);
  assign zero_word  = STOP_ON_ZERO && (rom_data == '0);
  assign push       = !redirect_valid && push_ok && !zero_word;
  assign push_entry = '{word: rom_data, pc: fetch_pc};

  // PC advances only on an accepted fetch; a full buffer simply re-reads
  // the same ROM address next cycle. The add wraps modulo 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc <= '0;
      stopped  <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      stopped  <= 1'b0;
    end else if (push_ok) begin
      if (zero_word) stopped  <= 1'b1;
      else           fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  fetch_fifo #(
    .entry_t (ifu_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Two instances share all inputs:
// dut_a stops on a zero word, dut_b (STOP_ON_ZERO=0) enqueues zeros.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_ready;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;

  logic [5:0]  pc_addr_a, instr_pc_a, pc_addr_b, instr_pc_b;
  logic [31:0] rom_a, rom_b, out_a, out_b;
  logic        valid_a, valid_b, done_a, done_b;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int pops0;

  always #5 clk = ~clk;

  // ROM: three program words, zeros, and a nonzero tagged region from 0x20.
  function automatic logic [31:0] rom(input logic [5:0] a);
    case (a)
      6'd0:    return 32'h0020_0003;
      6'd1:    return 32'h0020_0002;
      6'd2:    return 32'h1064_0022;
      default: return (a >= 6'd32) ? (32'hC000_0000 | {26'd0, a}) : 32'h0;
    endcase
  endfunction

  assign rom_a = rom(pc_addr_a);
  assign rom_b = rom(pc_addr_b);

  always @(posedge clk) if (valid_a && instr_ready) n_pops <= n_pops + 1;

  instr_fetch_unit #(.STOP_ON_ZERO(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr_a), .rom_data(rom_a),
    .instr_out(out_a), .instr_pc(instr_pc_a), .instr_valid(valid_a),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_done(done_a));

  instr_fetch_unit #(.STOP_ON_ZERO(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr_b), .rom_data(rom_b),
    .instr_out(out_b), .instr_pc(instr_pc_b), .instr_valid(valid_b),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fetch_done(done_b));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    check("rst_valid",   valid_a, 0);
    check("rst_out",     out_a, 0);
    check("rst_pc",      instr_pc_a, 0);
    check("rst_pc_addr", pc_addr_a, 0);
    check("rst_done",    done_a, 0);

    // Streaming three words then halting on the zero word
    rst_n = 1'b1;
    tick();
    check("s0_valid", valid_a, 1);
    check("s0_out",   out_a, 32'h0020_0003);
    check("s0_pc",    instr_pc_a, 0);
    check("s0_addr",  pc_addr_a, 1);
    tick();
    check("s1_out", out_a, 32'h0020_0002);
    check("s1_pc",  instr_pc_a, 1);
    tick();
    check("s2_out", out_a, 32'h1064_0022);
    check("s2_pc",  instr_pc_a, 2);
    tick();
    check("stop_valid", valid_a, 0);
    check("stop_done",  done_a, 1);
    check("stop_addr",  pc_addr_a, 3);
    check("nz_valid",   valid_b, 1);
    check("nz_pc",      instr_pc_b, 3);
    check("nz_out",     out_b, 0);
    tick();
    check("stop_addr2", pc_addr_a, 3);
    check("stop_done2", done_a, 1);

    // Redirect after fetch_done
    redirect_valid = 1'b1; redirect_pc = 6'h20;
    tick();
    redirect_valid = 1'b0;
    check("rd_done_clr", done_a, 0);
    check("rd_valid0",   valid_a, 0);
    check("rd_addr",     pc_addr_a, 6'h20);
    tick();
    check("rd_valid1", valid_a, 1);
    check("rd_pc",     instr_pc_a, 6'h20);
    check("rd_out",    out_a, 32'hC000_0020);

    // Backpressure
    rst_n = 1'b0; instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("bp_valid", valid_a, 1);
    check("bp_pc0",   instr_pc_a, 0);
    check("bp_out0",  out_a, 32'h0020_0003);
    check("bp_addr",  pc_addr_a, 2);
    instr_ready = 1'b1;
    tick();
    check("bp_pc1",  instr_pc_a, 1);
    check("bp_out1", out_a, 32'h0020_0002);
    tick();
    check("bp_pc2",  instr_pc_a, 2);
    check("bp_out2", out_a, 32'h1064_0022);
    tick();
    check("bp_empty", valid_a, 0);
    check("bp_done",  done_a, 1);

    // Redirect with a full buffer and a simultaneous pop
    rst_n = 1'b0; instr_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("fl_addr_full", pc_addr_a, 2);
    pops0 = n_pops;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'h20;
    tick();
    redirect_valid = 1'b0;
    check("fl_valid0", valid_a, 0);
    check("fl_addr",   pc_addr_a, 6'h20);
    tick();
    check("fl_valid1", valid_a, 1);
    check("fl_pc",     instr_pc_a, 6'h20);
    check("fl_pops",   n_pops - pops0, 1);
    tick();
    check("fl_pc_next", instr_pc_a, 6'h21);

    // PC wrap on the non-stopping instance
    redirect_valid = 1'b1; redirect_pc = 6'd62;
    tick();
    redirect_valid = 1'b0;
    check("wr_valid0", valid_b, 0);
    tick();
    check("wr_pc62",  instr_pc_b, 62);
    check("wr_out62", out_b, 32'hC000_003E);
    tick();
    check("wr_pc63",  instr_pc_b, 63);
    check("wr_out63", out_b, 32'hC000_003F);
    tick();
    check("wr_pc0",  instr_pc_b, 0);
    check("wr_out0", out_b, 32'h0020_0003);
    tick();
    check("wr_pc1",  instr_pc_b, 1);
    check("wr_out1", out_b, 32'h0020_0002);

    // Reset mid-stream with a full buffer
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 6'h20;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    check("mr_full_valid", valid_a, 1);
    check("mr_full_addr",  pc_addr_a, 6'h22);
    rst_n = 1'b0;
    tick();
    check("mr_valid", valid_a, 0);
    check("mr_addr",  pc_addr_a, 0);
    check("mr_out",   out_a, 0);
    rst_n = 1'b1; instr_ready = 1'b1;
    tick();
    check("mr_valid1", valid_a, 1);
    check("mr_pc",     instr_pc_a, 0);
    check("mr_out1",   out_a, 32'h0020_0003);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
